muldiv_issue: RTL and testbench
===============================

MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: WAIT-state cycle limit, used only when MULDIV_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op_valid  input  1  CPU presents an operation this cycle.
REQ-005 op_code  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (ignored).
REQ-006 op_a  input  32  operand A / MTHI/MTLO data.
REQ-007 op_b  input  32  operand B.
REQ-008 mf_req  input  1  CPU reads HI/LO (MFHI/MFLO) this cycle.
REQ-009 stall  output  1  CPU must hold its op/read; combinational.
REQ-010 busy  output  1  an operation is outstanding in the unit.
REQ-011 hi_out, lo_out  output  32 each  architectural HI/LO registers.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 unit_start  output  1  one-cycle start pulse to the iterative mul/div unit (drives its validIn).
REQ-014 unit_sel  output  1  0 multiplier, 1 divider.
REQ-015 unit_signed  output  1  1 for MULT/DIV, 0 for MULTU/DIVU.
REQ-016 unit_src_a, unit_src_b  output  32 each  registered operands (drive SrcA/SrcB).
REQ-017 unit_done  input  1  unit result valid (its validOut).
REQ-018 unit_hi, unit_lo  input  32 each  unit result (its Hi/Lo).

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT; only IDLE accepts operations.
REQ-020 Accept = op_valid & state==IDLE & op_code in 001..110; accepted op captured on that edge.
REQ-021 MULT/MULTU/DIV/DIVU accept: latch op_a/op_b into unit_src_a/b, set unit_sel/unit_signed, go ISSUE.
REQ-022 ISSUE lasts exactly one cycle with unit_start=1, then WAIT; unit_start is 0 in every other state.
REQ-023 unit_src_a/b, unit_sel, unit_signed stay stable from ISSUE until return to IDLE.
REQ-024 WAIT: on the edge where unit_done=1, hi_out<=unit_hi, lo_out<=unit_lo, go IDLE; busy is 0 the following cycle.
REQ-025 busy = (state != IDLE).
REQ-026 stall = busy & (op_valid | mf_req); stalled ops are not captured and have no effect.
REQ-027 MTHI/MTLO in IDLE: write op_a to hi_out/lo_out on the accept edge, no unit activity, stay IDLE.
REQ-028 DIV/DIVU with op_b==0: accepted, no unit_start, HI/LO unchanged, stay IDLE, no stall.
REQ-029 unit_done in IDLE or ISSUE is ignored; no register change.
REQ-030 Reserved op_code 111 or 000 with op_valid: ignored, no stall in IDLE.
REQ-031 Minimum round trip: accept edge, ISSUE cycle, then N unit cycles; back-to-back op accepted the cycle after the capture edge.

Reset
REQ-032 reset_n low asynchronously forces: state IDLE, hi_out=0, lo_out=0, unit_src_a/b=0, unit_sel=0, unit_signed=0, unit_start=0, err=0, timeout counter=0.
REQ-033 Reset during ISSUE/WAIT abandons the operation; a stale unit_done after release is ignored per REQ-029.

Configuration
REQ-034 Macro MULDIV_TIMEOUT_EN defined: WAIT counter counts from 0 each WAIT entry; if TIMEOUT_CYCLES cycles elapse without unit_done, go IDLE, HI/LO unchanged, set err=1; err clears on next accepted unit op.
REQ-035 MULDIV_TIMEOUT_EN undefined: no counter, WAIT held indefinitely, err tied 0.

Verification
REQ-036 DIV op_a=412, op_b=412, unit model 34-cycle latency -> one unit_start pulse, busy until capture, hi_out=0, lo_out=1.
REQ-037 DIVU op_a=100, op_b=7 -> hi_out=2, lo_out=14; MULT op_a=0xFFFFFFFD, op_b=5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1.
REQ-038 mf_req=1 and MTLO op_valid during WAIT -> stall=1 each cycle until capture, lo_out not overwritten by MTLO; stall=0 cycle after capture.
REQ-039 DIV op_b=0 with hi_out=0x12345678 -> no unit_start, busy=0, hi_out unchanged; MTHI 0xCAFEF00D in IDLE -> hi_out=0xCAFEF00D next cycle.
REQ-040 reset_n low mid-WAIT, unit_done pulsed 3 cycles after release -> hi_out=lo_out=0, state IDLE, busy=0.
REQ-041 With MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, unit never responds -> busy falls after 8 WAIT cycles, err=1; next MULTU clears err.

Source files
------------

// File: rtl/muldiv_issue.sv
// HI/LO issue/capture controller for an iterative mul/div unit; optional WAIT watchdog under MULDIV_TIMEOUT_EN.
// Latency: accept edge, one ISSUE cycle with unit_start, then WAIT until unit_done (MTHI/MTLO/div-by-zero take effect on the accept edge).
// Backpressure: while an op is outstanding, stall is raised combinationally for any op or HI/LO read and those requests are dropped.
module muldiv_issue #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mf_req,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        err,
    output logic        unit_start,
    output logic        unit_sel,
    output logic        unit_signed,
    output logic [31:0] unit_src_a,
    output logic [31:0] unit_src_b,
    input  logic        unit_done,
    input  logic [31:0] unit_hi,
    input  logic [31:0] unit_lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} stateT;

    stateT state;
    logic  accept;
    logic  isUnitOp;
    logic  isDiv;
    logic  divByZero;

    assign accept    = op_valid && (state == IDLE) && (op_code != 3'b000) && (op_code != 3'b111);
    assign isUnitOp  = (op_code == OP_MULT) || (op_code == OP_MULTU) || (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign isDiv     = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign divByZero = isDiv && (op_b == 32'd0);

    assign busy  = (state != IDLE);
    assign stall = busy && (op_valid || mf_req);

`ifdef MULDIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic [CW-1:0] waitCnt;
    logic          errReg;
    assign err = errReg;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hi_out      <= 32'd0;
            lo_out      <= 32'd0;
            unit_src_a  <= 32'd0;
            unit_src_b  <= 32'd0;
            unit_sel    <= 1'b0;
            unit_signed <= 1'b0;
            unit_start  <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            waitCnt     <= '0;
            errReg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_code == OP_MTHI) begin
                            hi_out <= op_a;
                        end else if (op_code == OP_MTLO) begin
                            lo_out <= op_a;
                        end else if (isUnitOp) begin
`ifdef MULDIV_TIMEOUT_EN
                            errReg <= 1'b0;
`endif
                            // Divide by zero retires silently: architectural HI/LO keep their values.
                            if (!divByZero) begin
                                unit_src_a  <= op_a;
                                unit_src_b  <= op_b;
                                unit_sel    <= isDiv;
                                unit_signed <= (op_code == OP_MULT) || (op_code == OP_DIV);
                                unit_start  <= 1'b1;
                                state       <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    unit_start <= 1'b0;
                    state      <= WAIT;
`ifdef MULDIV_TIMEOUT_EN
                    waitCnt    <= '0;
`endif
                end
                WAIT: begin
                    if (unit_done) begin
                        hi_out <= unit_hi;
                        lo_out <= unit_lo;
                        state  <= IDLE;
                    end
`ifdef MULDIV_TIMEOUT_EN
                    else if (waitCnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        errReg <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`endif
                end
                default: begin
                    unit_start <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// Randomized scoreboard bench for muldiv_issue with a behavioural mul/div unit model.
module tb_muldiv_issue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        mf_req = 1'b0;
    logic        stall, busy, err, unit_start, unit_sel, unit_signed;
    logic [31:0] hi_out, lo_out, unit_src_a, unit_src_b;
    logic        unit_done = 1'b0;
    logic [31:0] unit_hi = 32'd0;
    logic [31:0] unit_lo = 32'd0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] a;
        logic [31:0] b;
    } opT;

    opT          issueQ[$];
    logic [63:0] resQ[$];
    opT          cur;
    bit          curValid = 1'b0;

    int          unitLat = 4;
    bit          unitMute = 1'b0;
    bit          abortFlag = 1'b0;
    logic [31:0] refHi = 32'd0;
    logic [31:0] refLo = 32'd0;

    always #5 clk = ~clk;

    muldiv_issue #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .mf_req(mf_req), .stall(stall), .busy(busy),
        .hi_out(hi_out), .lo_out(lo_out), .err(err), .unit_start(unit_start),
        .unit_sel(unit_sel), .unit_signed(unit_signed), .unit_src_a(unit_src_a),
        .unit_src_b(unit_src_b), .unit_done(unit_done), .unit_hi(unit_hi), .unit_lo(unit_lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MIPS HI/LO semantics: product as {hi,lo}; divide gives hi=remainder, lo=quotient.
    function automatic logic [63:0] refCalc(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (code)
            3'd1: return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'd4: return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // Iterative unit model: answers unitLat cycles after seeing the start pulse.
    logic [63:0] modelRes;
    logic [2:0]  modelCode;
    initial begin
        forever begin
            @(negedge clk);
            if (unit_start) begin
                modelCode = unit_sel ? (unit_signed ? 3'd3 : 3'd4) : (unit_signed ? 3'd1 : 3'd2);
                modelRes  = refCalc(modelCode, unit_src_a, unit_src_b);
                if (!unitMute) begin
                    repeat (unitLat) @(negedge clk);
                    unit_done = 1'b1;
                    {unit_hi, unit_lo} = modelRes;
                    @(negedge clk);
                    unit_done = 1'b0;
                end
            end
        end
    end

    // Monitor: checks issued operands on unit_start, held operands in WAIT, results when busy falls.
    bit prevBusy = 1'b0;
    bit prevStart = 1'b0;
    always @(negedge clk) begin
        if (unit_start) begin
            check("start_width", 64'(prevStart), 64'd0);
            check("spurious_start", 64'(issueQ.size() == 0), 64'd0);
            if (issueQ.size() != 0) begin
                cur = issueQ.pop_front();
                curValid = 1'b1;
                check("issue_ops", {unit_src_a, unit_src_b}, {cur.a, cur.b});
                check("issue_mode", 64'({unit_sel, unit_signed}),
                      64'({cur.code >= 3'd3, (cur.code == 3'd1) || (cur.code == 3'd3)}));
            end
        end else if (busy && curValid && reset_n) begin
            check("hold_ops", {unit_src_a, unit_src_b}, {cur.a, cur.b});
        end
        if (prevBusy && !busy && reset_n && !abortFlag) begin
            check("result_pending", 64'(resQ.size() == 0), 64'd0);
            if (resQ.size() != 0) check("result", {hi_out, lo_out}, resQ.pop_front());
        end
        prevBusy  = busy;
        prevStart = unit_start;
    end

    // Waits out an outstanding op; mode 1 drives random requests, mode 2 holds MTLO + mf_req.
    task automatic waitIdle(input int mode, output int n);
        n = 0;
        while (busy && n < 400) begin
            if (mode == 1) begin
                op_valid = 1'($urandom_range(0, 1));
                op_code  = 3'($urandom);
                op_a     = $urandom;
                mf_req   = 1'($urandom_range(0, 1));
                #1 check("stall_wait", 64'(stall), 64'(op_valid | mf_req));
            end else if (mode == 2) begin
                op_valid = 1'b1;
                op_code  = 3'd6;
                op_a     = 32'hDEADBEEF;
                mf_req   = 1'b1;
                #1 check("stall_wait", 64'(stall), 64'd1);
            end
            @(negedge clk);
            n++;
        end
        check("idle_bound", 64'(busy), 64'd0);
        if (mode == 2) check("stall_after", 64'(stall), 64'd0);
        op_valid = 1'b0;
        mf_req   = 1'b0;
    endtask

    // Called at a negedge with the DUT idle.
    task automatic doOp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int mode);
        logic        issues;
        logic [63:0] res;
        int          n;
        issues  = (code >= 3'd1) && (code <= 3'd4) && !((code >= 3'd3) && (b == 32'd0));
        unitLat = lat;
        res     = 64'd0;
        if (issues) begin
            res = refCalc(code, a, b);
            issueQ.push_back('{code, a, b});
            resQ.push_back(res);
        end
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        #1 check("idle_stall", 64'(stall), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        if (code == 3'd5) refHi = a;
        if (code == 3'd6) refLo = a;
        if (issues) begin
            waitIdle(mode, n);
            check("round_trip", 64'(n), 64'(lat + 1));
            {refHi, refLo} = res;
        end else begin
            check("no_issue", 64'({busy, unit_start}), 64'd0);
            check("arch_regs", {hi_out, lo_out}, {refHi, refLo});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra, rb;
        int          n;

        repeat (3) @(negedge clk);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_src", {unit_src_a, unit_src_b}, 64'd0);
        check("reset_ctl", 64'({busy, stall, unit_start, unit_sel, unit_signed, err}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        doOp(3'd3, 32'd412, 32'd412, 34, 0);
        check("div412", {hi_out, lo_out}, {32'd0, 32'd1});
        doOp(3'd4, 32'd100, 32'd7, 5, 0);
        check("divu100_7", {hi_out, lo_out}, {32'd2, 32'd14});
        doOp(3'd1, 32'hFFFFFFFD, 32'd5, 3, 0);
        check("mult_neg", {hi_out, lo_out}, {32'hFFFFFFFF, 32'hFFFFFFF1});

        doOp(3'd5, 32'h12345678, 32'd0, 1, 0);
        doOp(3'd3, 32'd99, 32'd0, 1, 0);
        check("div0_hi", 64'(hi_out), 64'h12345678);
        doOp(3'd5, 32'hCAFEF00D, 32'd0, 1, 0);
        check("mthi", 64'(hi_out), 64'hCAFEF00D);

        doOp(3'd2, 32'd7, 32'd9, 6, 2);
        check("mtlo_blocked", 64'(lo_out), 64'd63);

        doOp(3'd0, 32'h55, 32'h66, 1, 0);
        doOp(3'd7, 32'h77, 32'h88, 1, 0);

        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (rc == 3'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            doOp(rc, ra, rb, $urandom_range(1, 8), $urandom_range(0, 1));
        end

        // Reset in the middle of WAIT; the unit answers 3 cycles after release.
        doOp(3'd5, 32'hA5A5A5A5, 32'd0, 1, 0);
        doOp(3'd6, 32'h5A5A5A5A, 32'd0, 1, 0);
        abortFlag = 1'b1;
        unitLat = 10;
        issueQ.push_back('{3'd3, 32'd1000, 32'd3});
        op_valid = 1'b1; op_code = 3'd3; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        curValid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        check("abort_busy", 64'({busy, unit_start}), 64'd0);
        refHi = 32'd0;
        refLo = 32'd0;
        abortFlag = 1'b0;
        doOp(3'd2, 32'd6, 32'd7, 2, 0);
        check("after_abort", 64'(lo_out), 64'd42);

`ifdef MULDIV_TIMEOUT_EN
        abortFlag = 1'b1;
        unitMute = 1'b1;
        issueQ.push_back('{3'd1, 32'h11, 32'h22});
        op_valid = 1'b1; op_code = 3'd1; op_a = 32'h11; op_b = 32'h22;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd9);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_hilo", {hi_out, lo_out}, {refHi, refLo});
        unitMute = 1'b0;
        abortFlag = 1'b0;
        doOp(3'd2, 32'd3, 32'd4, 2, 0);
        check("err_cleared", 64'(err), 64'd0);
`else
        check("err_tied", 64'(err), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
